// File: rtl/delay_corr_energy_param_if.sv
// Stream bundle for delay_corr_energy_param.
// EnergySum exists only when DCE_ENERGY_EN is defined.
interface delay_corr_energy_param_if #(
  parameter int DW      = 8,
  parameter int LOG2WIN = 4
);
  localparam int PW = 2*DW+1;
  localparam int SW = PW+LOG2WIN;
  localparam int MW = SW+1;

  logic                 InputEnable;
  logic signed [DW-1:0] DataInRe;
  logic signed [DW-1:0] DataInIm;
  logic                 OutputEnable;
  logic [MW-1:0]        CorrMagnitude;
  logic signed [SW-1:0] CorrSumRe;
  logic signed [SW-1:0] CorrSumIm;
`ifdef DCE_ENERGY_EN
  logic signed [SW-1:0] EnergySum;
`endif

  modport master (
    output InputEnable, DataInRe, DataInIm,
    input  OutputEnable, CorrMagnitude,
    input  CorrSumRe, CorrSumIm
`ifdef DCE_ENERGY_EN
    , input EnergySum
`endif
  );

  modport slave (
    input  InputEnable, DataInRe, DataInIm,
    output OutputEnable, CorrMagnitude,
    output CorrSumRe, CorrSumIm
`ifdef DCE_ENERGY_EN
    , output EnergySum
`endif
  );
endinterface

// File: rtl/delay_corr_energy_param.sv
// Lag-LAG delay correlation over a WIN-sample window, |Re|+|Im| out.
// Define DCE_ENERGY_EN to add the windowed sum(|B|^2) output.
module delay_corr_energy_param #(
  parameter int DW      = 8,
  parameter int LAG     = 16,
  parameter int LOG2WIN = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Clear,
  delay_corr_energy_param_if.slave io
);
  localparam int WIN  = 1 << LOG2WIN;
  localparam int PW   = 2*DW+1;
  localparam int SW   = PW+LOG2WIN;
  localparam int MW   = SW+1;
  localparam int FILL = LAG+WIN;
  localparam int CW   = $clog2(FILL+1);

  typedef logic signed [DW-1:0] smp_t;
  typedef logic signed [PW-1:0] prd_t;
  typedef logic signed [SW-1:0] sum_t;

  smp_t dl_re_q [LAG];
  smp_t dl_re_d [LAG];
  smp_t dl_im_q [LAG];
  smp_t dl_im_d [LAG];
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;

  smp_t are_q, are_d, aim_q, aim_d;
  smp_t bre_q, bre_d, bim_q, bim_d;
  logic v1_q, v1_d, g1_q, g1_d;

  prd_t pre_q, pre_d, pim_q, pim_d;
  logic v2_q, v2_d, g2_q, g2_d;

  prd_t hre_q [WIN];
  prd_t hre_d [WIN];
  prd_t him_q [WIN];
  prd_t him_d [WIN];
  sum_t acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic v3_q, v3_d, g3_q, g3_d;

  logic oe_q, oe_d;
  logic [MW-1:0] mag_q, mag_d;
  sum_t sre_q, sre_d, sim_q, sim_d;

`ifdef DCE_ENERGY_EN
  prd_t e_q, e_d;
  prd_t he_q [WIN];
  prd_t he_d [WIN];
  sum_t acc_e_q, acc_e_d, esum_q, esum_d;
`endif

  function automatic logic [MW-1:0] mag_of(input sum_t x);
    logic signed [MW-1:0] w;
    w = MW'(x);
    return (w < 0) ? MW'(-w) : MW'(w);
  endfunction

  always_comb begin
    dl_re_d  = dl_re_q;
    dl_im_d  = dl_im_q;
    cnt_nx   = (cnt_q == CW'(FILL)) ? cnt_q : cnt_q + 1'b1;
    cnt_d    = cnt_q;
    are_d    = are_q;
    aim_d    = aim_q;
    bre_d    = bre_q;
    bim_d    = bim_q;
    v1_d     = io.InputEnable;
    g1_d     = (cnt_nx == CW'(FILL));
    pre_d    = pre_q;
    pim_d    = pim_q;
    v2_d     = v1_q;
    g2_d     = g1_q;
    hre_d    = hre_q;
    him_d    = him_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    v3_d     = v2_q;
    g3_d     = g2_q;
    oe_d     = v3_q & g3_q;
    mag_d    = mag_q;
    sre_d    = sre_q;
    sim_d    = sim_q;
`ifdef DCE_ENERGY_EN
    e_d      = e_q;
    he_d     = he_q;
    acc_e_d  = acc_e_q;
    esum_d   = esum_q;
`endif

    if (io.InputEnable) begin
      are_d      = io.DataInRe;
      aim_d      = io.DataInIm;
      bre_d      = dl_re_q[LAG-1];
      bim_d      = dl_im_q[LAG-1];
      dl_re_d[0] = io.DataInRe;
      dl_im_d[0] = io.DataInIm;
      for (int i = 1; i < LAG; i++) begin
        dl_re_d[i] = dl_re_q[i-1];
        dl_im_d[i] = dl_im_q[i-1];
      end
      cnt_d = cnt_nx;
    end

    if (v1_q) begin
      pre_d = prd_t'(are_q) * prd_t'(bre_q)
            + prd_t'(aim_q) * prd_t'(bim_q);
      pim_d = prd_t'(aim_q) * prd_t'(bre_q)
            - prd_t'(are_q) * prd_t'(bim_q);
`ifdef DCE_ENERGY_EN
      e_d = prd_t'(bre_q) * prd_t'(bre_q)
          + prd_t'(bim_q) * prd_t'(bim_q);
`endif
    end

    if (v2_q) begin
      hre_d[0] = pre_q;
      him_d[0] = pim_q;
      for (int i = 1; i < WIN; i++) begin
        hre_d[i] = hre_q[i-1];
        him_d[i] = him_q[i-1];
      end
      acc_re_d = acc_re_q + sum_t'(pre_q) - sum_t'(hre_q[WIN-1]);
      acc_im_d = acc_im_q + sum_t'(pim_q) - sum_t'(him_q[WIN-1]);
`ifdef DCE_ENERGY_EN
      he_d[0] = e_q;
      for (int i = 1; i < WIN; i++) he_d[i] = he_q[i-1];
      acc_e_d = acc_e_q + sum_t'(e_q) - sum_t'(he_q[WIN-1]);
`endif
    end

    // Output registers move only on a live strobe, so they hold otherwise.
    if (v3_q && g3_q) begin
      mag_d = mag_of(acc_re_q) + mag_of(acc_im_q);
      sre_d = acc_re_q;
      sim_d = acc_im_q;
`ifdef DCE_ENERGY_EN
      esum_d = acc_e_q;
`endif
    end

    if (Clear) begin
      dl_re_d  = '{default: '0};
      dl_im_d  = '{default: '0};
      cnt_d    = '0;
      are_d    = '0;
      aim_d    = '0;
      bre_d    = '0;
      bim_d    = '0;
      v1_d     = 1'b0;
      g1_d     = 1'b0;
      pre_d    = '0;
      pim_d    = '0;
      v2_d     = 1'b0;
      g2_d     = 1'b0;
      hre_d    = '{default: '0};
      him_d    = '{default: '0};
      acc_re_d = '0;
      acc_im_d = '0;
      v3_d     = 1'b0;
      g3_d     = 1'b0;
      oe_d     = 1'b0;
      mag_d    = '0;
      sre_d    = '0;
      sim_d    = '0;
`ifdef DCE_ENERGY_EN
      e_d      = '0;
      he_d     = '{default: '0};
      acc_e_d  = '0;
      esum_d   = '0;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dl_re_q  <= '{default: '0};
      dl_im_q  <= '{default: '0};
      cnt_q    <= '0;
      are_q    <= '0;
      aim_q    <= '0;
      bre_q    <= '0;
      bim_q    <= '0;
      v1_q     <= 1'b0;
      g1_q     <= 1'b0;
      pre_q    <= '0;
      pim_q    <= '0;
      v2_q     <= 1'b0;
      g2_q     <= 1'b0;
      hre_q    <= '{default: '0};
      him_q    <= '{default: '0};
      acc_re_q <= '0;
      acc_im_q <= '0;
      v3_q     <= 1'b0;
      g3_q     <= 1'b0;
      oe_q     <= 1'b0;
      mag_q    <= '0;
      sre_q    <= '0;
      sim_q    <= '0;
`ifdef DCE_ENERGY_EN
      e_q      <= '0;
      he_q     <= '{default: '0};
      acc_e_q  <= '0;
      esum_q   <= '0;
`endif
    end else begin
      dl_re_q  <= dl_re_d;
      dl_im_q  <= dl_im_d;
      cnt_q    <= cnt_d;
      are_q    <= are_d;
      aim_q    <= aim_d;
      bre_q    <= bre_d;
      bim_q    <= bim_d;
      v1_q     <= v1_d;
      g1_q     <= g1_d;
      pre_q    <= pre_d;
      pim_q    <= pim_d;
      v2_q     <= v2_d;
      g2_q     <= g2_d;
      hre_q    <= hre_d;
      him_q    <= him_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      v3_q     <= v3_d;
      g3_q     <= g3_d;
      oe_q     <= oe_d;
      mag_q    <= mag_d;
      sre_q    <= sre_d;
      sim_q    <= sim_d;
`ifdef DCE_ENERGY_EN
      e_q      <= e_d;
      he_q     <= he_d;
      acc_e_q  <= acc_e_d;
      esum_q   <= esum_d;
`endif
    end
  end

  assign io.OutputEnable  = oe_q;
  assign io.CorrMagnitude = mag_q;
  assign io.CorrSumRe     = sre_q;
  assign io.CorrSumIm     = sim_q;
`ifdef DCE_ENERGY_EN
  assign io.EnergySum     = esum_q;
`endif

endmodule

// File: tb/tb_delay_corr_energy_param.sv
// Scoreboard bench for delay_corr_energy_param (default parameters).
// Reference model keeps whole sample history and sums windows directly.
module tb_delay_corr_energy_param;
  localparam int DW  = 8;
  localparam int LAG = 16;
  localparam int L2W = 4;
  localparam int WIN = 1 << L2W;

  typedef struct {
    longint re;
    longint im;
    longint mg;
    longint en;
    longint due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic clr_hit = 1'b0;
  longint cyc = 0;
  int tests = 0;
  int fails = 0;

  exp_t sb[$];
  longint xr[$], xi[$], pr[$], pi[$], pe[$];
  longint lr = 0, li = 0, lm = 0, le = 0;

  delay_corr_energy_param_if #(.DW(DW), .LOG2WIN(L2W)) bus ();

  delay_corr_energy_param #(
    .DW(DW), .LAG(LAG), .LOG2WIN(L2W)
  ) dut (
    .Clk(clk),
    .Rst_n(rst_n),
    .Clear(clear),
    .io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) clr_hit <= clear;

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint dut_en();
`ifdef DCE_ENERGY_EN
    return longint'(bus.EnergySum);
`else
    return 0;
`endif
  endfunction

  function automatic longint exp_en(input longint v);
`ifdef DCE_ENERGY_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic model_flush();
    xr.delete(); xi.delete();
    pr.delete(); pi.delete(); pe.delete();
  endtask

  task automatic model_push(input int re, input int im);
    int n;
    longint br, bi, sr, si, se;
    exp_t e;
    xr.push_back(re);
    xi.push_back(im);
    n = xr.size() - 1;
    br = (n >= LAG) ? xr[n-LAG] : 0;
    bi = (n >= LAG) ? xi[n-LAG] : 0;
    pr.push_back(re*br + im*bi);
    pi.push_back(im*br - re*bi);
    pe.push_back(br*br + bi*bi);
    if (n >= LAG + WIN - 1) begin
      sr = 0; si = 0; se = 0;
      for (int k = n - WIN + 1; k <= n; k++) begin
        sr += pr[k]; si += pi[k]; se += pe[k];
      end
      e.re = sr; e.im = si; e.mg = labs(sr) + labs(si);
      e.en = exp_en(se); e.due = cyc + 4;
      sb.push_back(e);
    end
  endtask

  // Called at posedge+#1; inputs land on the following edge.
  task automatic step(input bit en, input int re, input int im,
                      input bit clr);
    bus.InputEnable = en;
    bus.DataInRe = DW'(re);
    bus.DataInIm = DW'(im);
    clear = clr;
    if (clr) begin
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      model_flush();
    end else if (en) begin
      model_push(re, im);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string nm);
    tests++;
    if (bus.OutputEnable !== 1'b0 || bus.CorrMagnitude !== '0 ||
        bus.CorrSumRe !== '0 || bus.CorrSumIm !== '0 ||
        dut_en() != 0) begin
      fails++;
      $display("FAIL %s: oe=%0b mag=%0d re=%0d im=%0d en=%0d want all 0",
               nm, bus.OutputEnable, bus.CorrMagnitude,
               bus.CorrSumRe, bus.CorrSumIm, dut_en());
    end
  endtask

  task automatic pulse_reset();
    bus.InputEnable = 1'b0;
    rst_n = 1'b0;
    while (sb.size() > 0 && sb[$].due >= cyc) void'(sb.pop_back());
    model_flush();
    #1;
    check_zero("reset_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    longint ar, ai, am, ae;
    ar = longint'(bus.CorrSumRe);
    ai = longint'(bus.CorrSumIm);
    am = longint'(bus.CorrMagnitude);
    ae = dut_en();
    if (!rst_n || clr_hit) begin
      lr = 0; li = 0; lm = 0; le = 0;
    end
    if (bus.OutputEnable === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL strobe_unexpected: cyc=%0d mag=%0d want no strobe",
                 cyc, am);
      end else begin
        e = sb.pop_front();
        if (e.due != cyc || ar != e.re || ai != e.im ||
            am != e.mg || ae != e.en) begin
          fails++;
          $display("FAIL strobe: cyc=%0d re=%0d im=%0d mag=%0d en=%0d want cyc=%0d re=%0d im=%0d mag=%0d en=%0d",
                   cyc, ar, ai, am, ae, e.due, e.re, e.im, e.mg, e.en);
        end
        lr = e.re; li = e.im; lm = e.mg; le = e.en;
      end
    end else begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        tests++;
        fails++;
        $display("FAIL strobe_missing: cyc=%0d oe=0 want oe=1 due=%0d",
                 cyc, sb[0].due);
        void'(sb.pop_front());
      end
      tests++;
      if (ar != lr || ai != li || am != lm || ae != le) begin
        fails++;
        $display("FAIL hold: cyc=%0d re=%0d im=%0d mag=%0d en=%0d want re=%0d im=%0d mag=%0d en=%0d",
                 cyc, ar, ai, am, ae, lr, li, lm, le);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    int rr, ri;
    bus.InputEnable = 1'b0;
    bus.DataInRe = '0;
    bus.DataInIm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) step(1, 64, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    for (int i = 0; i < 10; i++) step(1, 64, 0, 0);
    pulse_reset();
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: step(1, 64, 0, 0);
        1: step(1, 0, 64, 0);
        2: step(1, -64, 0, 0);
        default: step(1, 0, -64, 0);
      endcase
    end
    repeat (6) step(0, 0, 0, 0);

    step(0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(1, 64, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end

    step(0, 0, 0, 1);
    for (int i = 0; i < 40; i++) step(1, -128, -128, 0);
    step(1, 5, 7, 1);
    check_zero("clear_with_enable");
    for (int i = 0; i < 36; i++) step(1, -128, -128, 0);
    repeat (6) step(0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      rr = int'($urandom_range(0, 255)) - 128;
      ri = int'($urandom_range(0, 255)) - 128;
      step($urandom_range(0, 3) != 0, rr, ri,
           $urandom_range(0, 79) == 0);
    end
    for (int i = 0; i < 100; i++) begin
      rr = int'($urandom_range(0, 255)) - 128;
      ri = int'($urandom_range(0, 255)) - 128;
      step(1, rr, ri, 0);
    end
    repeat (8) step(0, 0, 0, 0);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
